rectify: RTL
============

Name: rectify

Overview:
- Activation stage placed directly downstream of an associate layer.
- Consumes the signed Q8.8 weighted sum on the associate result stream and emits a saturated-linear activation as an unsigned Q0.8 byte. That byte is directly usable as one argument lane of the next associate layer.
- In training mode it accepts the backward error from the next layer, gates it by the activation derivative of the stored input, and propagates it upstream as the associate error.

Parameters:
- LEAK, 0: gradient shift outside the linear region. 0 means the propagated error is 0 outside the linear region; N>0 means the propagated error is err >>> N.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- train  input  1  training mode; sampled at the result handshake
- argument_valid  input  1  forward input valid
- argument_ready  output  1  forward input ready
- argument_data  input  16  signed Q8.8 weighted sum
- result_valid  output  1  activation valid
- result_ready  input  1  activation accepted
- result_data  output  8  unsigned Q0.8 activation
- error_valid  input  1  backward error valid
- error_ready  output  1  backward error ready
- error_data  input  16  signed Q8.8 error
- propagate_valid  output  1  gated error valid
- propagate_ready  input  1  gated error accepted
- propagate_data  output  16  signed Q8.8 gated error, sent upstream as the associate error

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - state=ARG; argument_ready=1; result_valid=0; error_ready=0; propagate_valid=0.
  - result_data=0; propagate_data=0; stored x=0.
- Handshake rules:
  - A transfer occurs on a rising edge where valid && ready.
  - Each output's valid and data hold stable until accepted.
  - Valid never depends combinationally on ready.
  - At most one forward sample is in flight at a time.
- FSM, four states; exactly one of the ready/valid outputs is 1 per state:
  - ARG: argument_ready=1. On argument transfer: latch x=argument_data, register result_data=f(x), register lin(x), go to RES.
  - RES: result_valid=1. On result transfer: if train=1 go to ERR, else go to ARG.
  - ERR: error_ready=1. On error transfer: register propagate_data=g(error_data), go to PRP.
  - PRP: propagate_valid=1. On propagate transfer: go to ARG.
- Latency:
  - result_valid rises 1 cycle after the argument transfer.
  - propagate_valid rises 1 cycle after the error transfer.
  - Throughput is 1 sample per 2 cycles in inference mode, with ready/valid held high.
- Forward function f, with x signed:
  - x<0 gives 0x00.
  - x>0x00FF gives 0xFF.
  - Otherwise x[7:0].
  - lin(x) = (0 <= x <= 0x00FF), inclusive at both ends.
- Backward function g:
  - If lin: g(e) = e.
  - Otherwise, if LEAK=0: g(e) = 0.
  - Otherwise: g(e) = e >>> LEAK, arithmetic shift with sign preserved.
- Boundary conditions:
  - x=0x0000 and x=0x00FF are linear, so the error passes through.
  - x=0x0100 saturates to 0xFF and is non-linear.
  - x=0xFFFF (-1/256) gives 0x00 and is non-linear.
  - error_valid asserted outside ERR is not accepted (error_ready=0); it stalls until the block reaches ERR.
  - train changing in ERR or PRP has no effect: once entered, the backward pass always completes.
  - train is ignored in ARG.
  - Reset asserted mid-operation aborts any pending result or propagate. All valids drop immediately (asynchronous); no partial transfer is completed.
  - Back-pressure: result_ready=0 holds RES indefinitely with result_data stable. Likewise propagate_ready=0 holds PRP indefinitely with propagate_data stable.

Test Plan:
- Reset/idle: reset=0 then released → argument_ready=1, all valids 0, result_data=0x00, propagate_data=0x0000.
- Forward saturation, train=0, arguments 0xFF00, 0x0000, 0x0080, 0x00FF, 0x0100, 0x7FFF → results 0x00, 0x00, 0x80, 0xFF, 0xFF, 0xFF. Each result_valid appears 1 cycle after its transfer; the block returns to ARG with no error_ready.
- Backward gating, train=1, LEAK=0:
  - argument 0x0040, error 0xFF80 → propagate 0xFF80.
  - argument 0x0200, error 0x0100 → propagate 0x0000.
  - argument 0xFF00, error 0x0100 → propagate 0x0000.
- Leaky gradient, LEAK=2: argument 0x8000, error 0xFF00 → propagate 0xFFC0; argument 0x00FF, error 0xFF00 → propagate 0xFF00.
- Ordering/back-pressure, train=1:
  - error_valid=1 driven before the result is accepted → error_ready stays 0.
  - Hold result_ready=0 for 5 cycles → result_data is stable throughout.
  - Drop train while in ERR → the error is still consumed and propagate is still produced.
- Reset mid-operation: assert reset while in PRP with propagate_ready=0 → propagate_valid falls without waiting for a clock edge. After release the block is in ARG and the next forward 0x0010 gives 0x10.

Source files
------------

// File: rtl/rectify.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rectify
//   Activation stage that sits directly behind an associate layer.
//   Forward: takes a signed Q8.8 weighted sum and returns a saturated-linear
//   activation as an unsigned Q0.8 byte. This byte is usable as an argument
//   lane of the next associate layer.
//   Backward (train=1): takes the error from the next layer and gates it with
//   the activation derivative of the stored input. The gated error is sent
//   upstream as the associate error.
//
// Parameters
//   LEAK : gradient shift outside the linear region. 0 blocks the error
//          completely; N>0 passes err >>> N.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous active-low reset
//   train            training mode, sampled when the result is accepted
//   argument_*       forward input stream, 16-bit signed Q8.8
//   result_*         activation output stream, 8-bit unsigned Q0.8
//   error_*          backward error input stream, 16-bit signed Q8.8
//   propagate_*      gated error output stream, 16-bit signed Q8.8
//
// Only one sample is in flight at a time. The FSM is one-hot, and exactly one
// ready/valid output is high in each state. Because of that, every handshake
// output is a decode of the state register. No handshake output depends
// combinationally on an incoming ready or valid.
// -----------------------------------------------------------------------------
module rectify #(
  parameter int unsigned LEAK = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        train,
  input  logic        argument_valid,
  output logic        argument_ready,
  input  logic [15:0] argument_data,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [7:0]  result_data,
  input  logic        error_valid,
  output logic        error_ready,
  input  logic [15:0] error_data,
  output logic        propagate_valid,
  input  logic        propagate_ready,
  output logic [15:0] propagate_data
);

  typedef enum logic [3:0] {
    S_ARG = 4'b0001,
    S_RES = 4'b0010,
    S_ERR = 4'b0100,
    S_PRP = 4'b1000
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_x;
  logic [7:0]  r_result;
  logic [15:0] r_prop;

  logic        w_arg_fire;
  logic        w_res_fire;
  logic        w_err_fire;
  logic        w_prp_fire;
  logic        w_lin;
  logic [15:0] w_grad;

  // Linear region is 0 <= x <= 0x00FF: the sign bit is clear and the integer
  // bits above bit 7 are zero.
  function automatic logic is_linear(input logic [15:0] x);
    return (x[15] == 1'b0) && (x[14:8] == 7'd0);
  endfunction

  // Saturated-linear activation: clamp to the range [0, 0xFF].
  function automatic logic [7:0] activate(input logic [15:0] x);
    logic [7:0] y;
    if (x[15] == 1'b1) begin
      y = 8'h00;
    end else if (x[14:8] != 7'd0) begin
      y = 8'hFF;
    end else begin
      y = x[7:0];
    end
    return y;
  endfunction

  assign argument_ready  = (r_state == S_ARG);
  assign result_valid    = (r_state == S_RES);
  assign error_ready     = (r_state == S_ERR);
  assign propagate_valid = (r_state == S_PRP);
  assign result_data     = r_result;
  assign propagate_data  = r_prop;

  assign w_arg_fire = argument_valid  && (r_state == S_ARG);
  assign w_res_fire = result_ready    && (r_state == S_RES);
  assign w_err_fire = error_valid     && (r_state == S_ERR);
  assign w_prp_fire = propagate_ready && (r_state == S_PRP);

  // The derivative gate is taken from the stored input. r_x is held
  // unchanged from the argument transfer until the next argument is accepted.
  assign w_lin = is_linear(r_x);

  // Backward gating of the incoming error.
  always_comb begin
    w_grad = 16'h0000;
    if (w_lin) begin
      w_grad = error_data;
    end else if (LEAK == 32'd0) begin
      w_grad = 16'h0000;
    end else begin
      w_grad = $signed(error_data) >>> LEAK;
    end
  end

  // Next-state logic. train is looked at only when the result is accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ARG: begin
        if (w_arg_fire) begin
          w_state_nxt = S_RES;
        end else begin
          w_state_nxt = S_ARG;
        end
      end
      S_RES: begin
        if (w_res_fire && train) begin
          w_state_nxt = S_ERR;
        end else if (w_res_fire) begin
          w_state_nxt = S_ARG;
        end else begin
          w_state_nxt = S_RES;
        end
      end
      S_ERR: begin
        if (w_err_fire) begin
          w_state_nxt = S_PRP;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      S_PRP: begin
        if (w_prp_fire) begin
          w_state_nxt = S_ARG;
        end else begin
          w_state_nxt = S_PRP;
        end
      end
      default: begin
        w_state_nxt = S_ARG;
      end
    endcase
  end

  // State register. The asynchronous reset drops every valid at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_ARG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Forward datapath: capture x and the activation when the argument is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x      <= 16'h0000;
      r_result <= 8'h00;
    end else if (w_arg_fire) begin
      r_x      <= argument_data;
      r_result <= activate(argument_data);
    end
  end

  // Backward datapath: capture the gated error when the error is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prop <= 16'h0000;
    end else if (w_err_fire) begin
      r_prop <= w_grad;
    end
  end

endmodule
